// File: rtl/sysad_req_sched.sv
// Round-robin scheduler sharing the cpu-side SysAD bus among NREQ single-word requesters.
// Latency: write grant->done 3 cycles; read 4 cycles plus response wait (bounded by TIMEOUT).
// Backpressure: no grant while the registered e_ok is low; requests stay pending until done.
module sysad_req_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                sysclk,
  input  logic                reset_l,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [32*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0]  req_wdata,
  output logic                done,
  output logic [2:0]          done_id,
  output logic [31:0]         rdata,
  output logic                err,
  input  logic                e_ok_l,
  input  logic                e_valid_l,
  output logic                p_valid_l,
  input  logic [31:0]         sys_ad_in,
  input  logic [4:0]          sys_cmd_in,
  output logic [31:0]         sys_ad_out,
  output logic [4:0]          sys_cmd_out,
  output logic                sys_ad_oe
);

  localparam logic [4:0]  RD_WORD      = 5'b00011;
  localparam logic [4:0]  WR_WORD      = 5'b01011;
  localparam logic [4:0]  WR_DATA_LAST = 5'b11000;
  localparam logic [15:0] TO_LAST      = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_ID      = 3'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RTURN, RWAIT, RBACK, FIN} state_t;

  state_t      state, nxt;
  logic        e_ok_r, e_valid_r;
  logic [31:0] ad_r;
  logic [4:0]  cmd_r;
  logic [2:0]  rr, id_q;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] cnt;

  logic        gnt_vld, hi_vld;
  logic [2:0]  gnt_id, hi_id, lo_id;
  logic        sel_wr;
  logic [31:0] sel_addr, sel_wdata;
  logic        resp, grant;
  logic        unused_cmd_bits;

  assign resp            = e_valid_r && cmd_r[4];
  assign grant           = (state == IDLE) && gnt_vld && e_ok_r;
  assign done_id         = id_q;
  assign unused_cmd_bits = ^cmd_r[3:0];

  // Round-robin pick: lowest pending index at or above rr, else lowest pending overall.
  always_comb begin
    gnt_vld = 1'b0;
    hi_vld  = 1'b0;
    hi_id   = 3'd0;
    lo_id   = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        lo_id   = 3'(i);
        if (3'(i) >= rr) begin
          hi_vld = 1'b1;
          hi_id  = 3'(i);
        end
      end
    end
    gnt_id = hi_vld ? hi_id : lo_id;
  end

  // Select the granted requester's command fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == gnt_id) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge sysclk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= nxt;
  end

  // Next state and bus drive; the bus is released from RTURN through RWAIT.
  always_comb begin
    nxt         = state;
    p_valid_l   = 1'b1;
    sys_ad_oe   = 1'b1;
    sys_ad_out  = 32'd0;
    sys_cmd_out = 5'd0;
    done        = 1'b0;
    case (state)
      IDLE:  if (grant) nxt = CMD;
      CMD: begin
        p_valid_l   = 1'b0;
        sys_ad_out  = addr_q;
        sys_cmd_out = wr_q ? WR_WORD : RD_WORD;
        nxt         = wr_q ? WDATA : RTURN;
      end
      WDATA: begin
        p_valid_l   = 1'b0;
        sys_ad_out  = wdata_q;
        sys_cmd_out = WR_DATA_LAST;
        nxt         = FIN;
      end
      RTURN: begin
        sys_ad_oe = 1'b0;
        nxt       = RWAIT;
      end
      RWAIT: begin
        sys_ad_oe = 1'b0;
        if (resp || cnt == TO_LAST) nxt = RBACK;
      end
      RBACK: nxt = FIN;
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Input sampling, grant capture, wait counter and read result.
  always_ff @(posedge sysclk or negedge reset_l) begin
    if (!reset_l) begin
      e_ok_r    <= 1'b0;
      e_valid_r <= 1'b0;
      ad_r      <= 32'd0;
      cmd_r     <= 5'd0;
      rr        <= 3'd0;
      id_q      <= 3'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cnt       <= 16'd0;
      rdata     <= 32'd0;
      err       <= 1'b0;
    end else begin
      e_ok_r    <= ~e_ok_l;
      e_valid_r <= ~e_valid_l;
      ad_r      <= sys_ad_in;
      cmd_r     <= sys_cmd_in;
      if (grant) begin
        id_q    <= gnt_id;
        wr_q    <= sel_wr;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        rr      <= (gnt_id == LAST_ID) ? 3'd0 : gnt_id + 3'd1;
      end
      if (state == RTURN) cnt <= 16'd0;
      if (state == RWAIT) begin
        cnt <= cnt + 16'd1;
        if (resp) begin
          rdata <= ad_r;
          err   <= 1'b0;
        end else if (cnt == TO_LAST) begin
          rdata <= 32'd0;
          err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysad_req_sched.sv
// Directed bench for sysad_req_sched: write, read, arbitration, e_ok stall, timeout, reset.
// Inputs are driven 1 time unit after posedge and outputs sampled at the same point.
// Expected values are hand-derived constants per scenario.
module tb_sysad_req_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic              sysclk = 1'b0;
  logic              reset_l;
  logic [NREQ-1:0]   req, req_wr;
  logic [32*NREQ-1:0] req_addr, req_wdata;
  logic              done, err;
  logic [2:0]        done_id;
  logic [31:0]       rdata;
  logic              e_ok_l, e_valid_l, p_valid_l, sys_ad_oe;
  logic [31:0]       sys_ad_in, sys_ad_out;
  logic [4:0]        sys_cmd_in, sys_cmd_out;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 sysclk = ~sysclk;

  sysad_req_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .sysclk(sysclk), .reset_l(reset_l),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .done_id(done_id), .rdata(rdata), .err(err),
    .e_ok_l(e_ok_l), .e_valid_l(e_valid_l), .p_valid_l(p_valid_l),
    .sys_ad_in(sys_ad_in), .sys_cmd_in(sys_cmd_in),
    .sys_ad_out(sys_ad_out), .sys_cmd_out(sys_cmd_out), .sys_ad_oe(sys_ad_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_wr[id]             = wr;
    req_addr[32*id +: 32]  = a;
    req_wdata[32*id +: 32] = d;
    req[id]                = 1'b1;
  endtask

  task automatic respond(input logic [31:0] d);
    e_valid_l  = 1'b0;
    sys_ad_in  = d;
    sys_cmd_in = 5'b10000;
  endtask

  task automatic unrespond;
    e_valid_l  = 1'b1;
    sys_ad_in  = 32'd0;
    sys_cmd_in = 5'd0;
  endtask

  // Read on requester id; response (if resp_cyc>0) visible in RWAIT cycle resp_cyc.
  task automatic do_read(input int id, input logic [31:0] a, input int resp_cyc,
                         input logic [31:0] d, input int max_wait, input string tag);
    int oe_hi;
    set_req(id, 1'b0, a, 32'd0);
    tick;
    check({tag, "_cmd"}, {27'd0, sys_cmd_out}, 32'h03);
    check({tag, "_addr"}, sys_ad_out, a);
    tick;
    check({tag, "_rturn_oe"}, 32'(sys_ad_oe), 32'd0);
    oe_hi = 0;
    for (int n = 1; n <= max_wait; n++) begin
      tick;
      if (sys_ad_oe !== 1'b0 || p_valid_l !== 1'b1) oe_hi++;
      if (n == resp_cyc - 1) respond(d);
      if (n == resp_cyc) unrespond;
    end
    check({tag, "_wait_oe_low"}, 32'(oe_hi), 32'd0);
    tick;
    check({tag, "_rback_oe"}, 32'(sys_ad_oe), 32'd1);
    tick;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_id"}, 32'(done_id), 32'(id));
    req[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, pv_lo, dn;
    reset_l    = 1'b0;
    req        = '0;
    req_wr     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    e_ok_l     = 1'b0;
    e_valid_l  = 1'b1;
    sys_ad_in  = 32'd0;
    sys_cmd_in = 5'd0;
    tick;
    tick;
    check("rst_pvalid", 32'(p_valid_l), 32'd1);
    check("rst_oe", 32'(sys_ad_oe), 32'd1);
    check("rst_ad", sys_ad_out, 32'd0);
    check("rst_cmd", {27'd0, sys_cmd_out}, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_l = 1'b1;
    tick;
    tick;

    // Single write on requester 0.
    set_req(0, 1'b1, 32'h04300004, 32'h12345678);
    tick;
    check("wr_cmd_pv", 32'(p_valid_l), 32'd0);
    check("wr_cmd_ad", sys_ad_out, 32'h04300004);
    check("wr_cmd_cmd", {27'd0, sys_cmd_out}, 32'h0B);
    tick;
    check("wr_data_ad", sys_ad_out, 32'h12345678);
    check("wr_data_cmd", {27'd0, sys_cmd_out}, 32'h18);
    check("wr_data_oe", 32'(sys_ad_oe), 32'd1);
    tick;
    check("wr_done", 32'(done), 32'd1);
    check("wr_done_id", 32'(done_id), 32'd0);
    check("wr_fin_pv", 32'(p_valid_l), 32'd1);
    req[0] = 1'b0;
    tick;
    check("wr_done_pulse", 32'(done), 32'd0);

    // Read on requester 2, response visible in RWAIT cycle 5.
    do_read(2, 32'h00001000, 5, 32'hCAFEF00D, 5, "rd");
    check("rd_rdata", rdata, 32'hCAFEF00D);
    check("rd_err", 32'(err), 32'd0);
    tick;
    check("rd_rdata_hold", rdata, 32'hCAFEF00D);

    // e_ok deasserted: request on requester 1 must wait.
    e_ok_l = 1'b1;
    tick;
    set_req(1, 1'b1, 32'h00000040, 32'h55AA55AA);
    pv_lo = 0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (p_valid_l !== 1'b1) pv_lo++;
    end
    check("eok_stall_pv", 32'(pv_lo), 32'd0);
    e_ok_l = 1'b0;
    tick;
    check("eok_1st_cycle_pv", 32'(p_valid_l), 32'd1);
    tick;
    check("eok_2nd_cycle_pv", 32'(p_valid_l), 32'd0);
    check("eok_cmd_ad", sys_ad_out, 32'h00000040);
    tick;
    tick;
    check("eok_done_id", {29'd0, done_id} & {31'd0, done} | 32'(done_id), 32'd1);
    check("eok_done", 32'(done), 32'd1);
    req[1] = 1'b0;
    tick;

    // Timeout with no response, then response on the final wait cycle.
    do_read(3, 32'h00002000, 0, 32'd0, TIMEOUT, "to");
    check("to_err", 32'(err), 32'd1);
    check("to_rdata", rdata, 32'd0);
    tick;
    do_read(3, 32'h00002004, TIMEOUT, 32'h0BADBEEF, TIMEOUT, "to_edge");
    check("to_edge_err", 32'(err), 32'd0);
    check("to_edge_rdata", rdata, 32'h0BADBEEF);
    tick;

    // Reset pulsed during RWAIT.
    set_req(0, 1'b0, 32'h00003000, 32'd0);
    tick;
    tick;
    tick;
    tick;
    check("rst_mid_oe_before", 32'(sys_ad_oe), 32'd0);
    reset_l = 1'b0;
    #1;
    check("rst_mid_oe", 32'(sys_ad_oe), 32'd1);
    check("rst_mid_pv", 32'(p_valid_l), 32'd1);
    check("rst_mid_rdata", rdata, 32'd0);
    req[0] = 1'b0;
    dn = 0;
    for (int n = 0; n < 3; n++) begin
      tick;
      if (done) dn++;
    end
    reset_l = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick;
      if (done) dn++;
    end
    check("rst_mid_no_done", 32'(dn), 32'd0);

    // All four requesters held: strict rotation from rr=0.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i));
    for (int g = 0; g < 6; g++) begin
      int id;
      cnt = 0;
      while (!done && cnt < 20) begin
        tick;
        cnt++;
      end
      check("rr_done_seen", 32'(done), 32'd1);
      check("rr_order", 32'(done_id), 32'(g % NREQ));
      if (g > 0) check("rr_gap", 32'(cnt), 32'd3);
      id = int'(done_id);
      req[id] = 1'b0;
      tick;
      req[id] = 1'b1;
    end
    req = '0;
    tick;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
